// File: rtl/seq_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// seq_muldiv_pkg : shared FSM encoding, opcode constants and counter sizing
// Revision: 1.0
// ============================================================================
package seq_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv_step.sv
`default_nettype none
// ============================================================================
// seq_muldiv_step : one combinational shift-add multiply / restoring divide step
// Revision: 1.0
// ============================================================================
module seq_muldiv_step
  import seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt,
  output logic [WIDTH-1:0]   rem_nxt,
  output logic [WIDTH-1:0]   quo_nxt
);

  // Partial remainder needs one extra bit before the trial subtraction.
  logic [WIDTH:0] rem_sh;
  logic           rem_ge;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign rem_ge = (rem_sh >= {1'b0, divisor});

  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_nxt    = rem;
    quo_nxt    = quo;
    if (op == OP_MUL) begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = {mcand[2*WIDTH-2:0], 1'b0};
      mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
    end else begin
      // The true difference is below the divisor, so the low WIDTH bits suffice.
      rem_nxt = rem_ge ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], rem_ge};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// seq_muldiv_ctrl : start/done sequencer for iterative unsigned multiply/divide
// Optional: SEQ_MULDIV_EARLY_TERM_EN ends a multiply once the multiplier is 0.
// Revision: 1.0
// ============================================================================
module seq_muldiv_ctrl
  import seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 div_zero_q, div_zero_d;

  logic [2*WIDTH-1:0]   acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]     mplier_nxt, rem_nxt, quo_nxt;
  logic                 early_done;

  seq_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op         (op_q),
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .rem        (rem_q),
    .quo        (quo_q),
    .divisor    (divisor_q),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt),
    .rem_nxt    (rem_nxt),
    .quo_nxt    (quo_nxt)
  );

`ifdef SEQ_MULDIV_EARLY_TERM_EN
  assign early_done = (op_q == OP_MUL) && (mplier_nxt == '0);
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          op_d      = op;
          acc_d     = '0;
          mcand_d   = {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          rem_d     = '0;
          quo_d     = a;
          divisor_d = b;
        end
      end
      ST_CALC: begin
        cnt_d    = cnt_q + CW'(1);
        acc_d    = acc_nxt;
        mcand_d  = mcand_nxt;
        mplier_d = mplier_nxt;
        rem_d    = rem_nxt;
        quo_d    = quo_nxt;
        // With a zero divisor every trial subtract succeeds, so the
        // quotient fills with ones and the dividend shifts into rem.
        if ((cnt_q == CNT_LAST) || early_done) begin
          state_d    = ST_DONE;
          result_d   = (op_q == OP_DIV) ? {rem_nxt, quo_nxt} : acc_nxt;
          div_zero_d = (op_q == OP_DIV) && (divisor_q == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == ST_CALC);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seq_muldiv_ctrl : directed + random checks against an arithmetic model
// Honours SEQ_MULDIV_EARLY_TERM_EN when computing expected multiply latency.
// Revision: 1.0
// ============================================================================
module tb_seq_muldiv_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_zero;

  int passed = 0;
  int total  = 0;

  seq_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [2*W-1:0] ref_result(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int p, q, r;
    logic [2*W-1:0] res;
    logic [W-1:0] ones;
    ones = '1;
    if (!o) begin
      p   = int'(x) * int'(y);
      res = p[2*W-1:0];
    end else if (y == 0) begin
      res = {x, ones};
    end else begin
      q   = int'(x) / int'(y);
      r   = int'(x) % int'(y);
      res = {r[W-1:0], q[W-1:0]};
    end
    return res;
  endfunction

  function automatic int ref_lat(input logic o, input logic [W-1:0] y);
    int lat;
    lat = W;
`ifdef SEQ_MULDIV_EARLY_TERM_EN
    if (!o) begin
      lat = 1;
      for (int i = 0; i < W; i++) if (y[i]) lat = i + 1;
    end
`endif
    return lat;
  endfunction

  // Called on a falling edge while the DUT accepts; returns on the falling
  // edge of the done cycle. hold keeps start high with junk operands inside CALC.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold);
    int  n;
    bit  busy_ok;
    busy_ok = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    n = 0;
    repeat (hold) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      start = 1'b1; op = ~o; a = W'($urandom); b = W'($urandom);
      n++;
      @(negedge clk);
    end
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = ~o;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, ".done"},     32'(done),     32'd1);
    check({tag, ".busy_run"}, 32'(busy_ok),  32'd1);
    check({tag, ".latency"},  32'(n),        32'(ref_lat(o, y)));
    check({tag, ".busy_end"}, 32'(busy),     32'd0);
    check({tag, ".result"},   32'(result),   32'(ref_result(o, x, y)));
    check({tag, ".div_zero"}, 32'(div_zero), 32'(o && (y == 0)));
  endtask

  initial begin
    logic [2*W-1:0] held;
    bit             saw_done;
    logic           ro;
    logic [W-1:0]   rx, ry;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    check("reset.busy",     32'(busy),     32'd0);
    check("reset.done",     32'(done),     32'd0);
    check("reset.result",   32'(result),   32'd0);
    check("reset.div_zero", 32'(div_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul15x15", 1'b0, 4'd15, 4'd15, 0);
    check("mul15x15.const", 32'(result), 32'd225);
    @(negedge clk);
    run_op("div13by3", 1'b1, 4'd13, 4'd3, 0);
    check("div13by3.const", 32'(result), 32'h14);
    @(negedge clk);
    run_op("div9by0", 1'b1, 4'd9, 4'd0, 0);
    check("div9by0.const", 32'(result), 32'h9F);
    @(negedge clk);

    // start during CALC is ignored; next request issued in the done cycle
    run_op("mul5x6_ign", 1'b0, 4'd5, 4'd6, 1);
    check("mul5x6.const", 32'(result), 32'd30);
    run_op("b2b_div7by2", 1'b1, 4'd7, 4'd2, 0);
    check("b2b_div7by2.const", 32'(result), 32'h13);
    held = result;
    @(negedge clk);
    check("hold.done",   32'(done),   32'd0);
    check("hold.result", 32'(result), 32'(held));

    // asynchronous reset in the second CALC cycle
    start = 1'b1; op = 1'b0; a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.busy",   32'(busy),   32'd0);
    check("midrst.done",   32'(done),   32'd0);
    check("midrst.result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (2 * W + 2) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst.no_done", 32'(saw_done), 32'd0);
    run_op("mul3x4", 1'b0, 4'd3, 4'd4, 0);
    check("mul3x4.const", 32'(result), 32'd12);
    @(negedge clk);

    run_op("mul7x1", 1'b0, 4'd7, 4'd1, 0);
    @(negedge clk);
    run_op("mul7x8", 1'b0, 4'd7, 4'd8, 0);
    @(negedge clk);
    run_op("mul9x0", 1'b0, 4'd9, 4'd0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = W'($urandom);
      ry = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op($sformatf("rand%0d", i), ro, rx, ry, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_muldiv_ctrl.md
Name: seq_muldiv_ctrl

Overview:
- Iterative controller that sequences the shared narrow adder/subtractor datapath for multi-cycle unsigned multiply (shift-and-add) and divide (restoring).
- It replaces the combinational ×2 and ÷2 shift helpers with a full N-bit × N-bit multiply and N-bit ÷ N-bit divide.
- Sits between the arithmetic unit and any requester, using a start/done handshake.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH. Legal range is 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request pulse; sampled only when the block is accepting
- op  in  1  0 = multiply, 1 = divide; sampled with start
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse; results valid this cycle and held afterwards
- result  out  2*WIDTH  multiply: product. Divide: {remainder, quotient}, with remainder in the upper WIDTH bits.
- div_zero  out  1  set at done when a divide had b == 0; held with result

Behaviour:
- Reset, asynchronous: state = IDLE; busy, done, div_zero = 0; result = 0; all internal registers = 0.
- Reset asserted mid-operation aborts immediately. No done is produced and result returns to 0.
- FSM states: IDLE, CALC, DONE.
- Accepting states are IDLE and DONE. In either state, start = 1 captures op, a and b and moves to CALC at the next edge.
  - This allows back-to-back requests: start in the DONE cycle is accepted.
- start while in CALC is ignored. No queuing.
- busy = 1 exactly while state == CALC.
- CALC runs for exactly WIDTH cycles, tracked by a step counter from 0 to WIDTH-1. It then moves to DONE.
- DONE lasts one cycle:
  - done = 1;
  - result and div_zero are registered in the same cycle;
  - next state is IDLE unless start is accepted.
- Latency: start sampled at edge T, so done is high in the cycle after edge T+WIDTH. Result is stable from then until the next done.
- Multiply step:
  - if mplier[0], acc = acc + mcand;
  - then mcand <<= 1 and mplier >>= 1;
  - acc and mcand are 2*WIDTH bits wide, so no overflow is possible.
- Divide step (restoring):
  - rem = {rem[WIDTH-1:0], quo[WIDTH-1]}, then quo <<= 1;
  - if rem >= divisor: rem = rem - divisor and quo[0] = 1;
  - rem is WIDTH+1 bits wide internally.
- Divide by zero:
  - the full WIDTH-cycle latency is kept;
  - quotient is forced to all ones and remainder = a;
  - div_zero = 1.
- div_zero is 0 for every multiply.
- Operands are unsigned. No sign handling.

Optional Feature:
- Macro: SEQ_MULDIV_EARLY_TERM_EN.
- Defined, multiply only: if the shifted multiplier becomes 0 after a CALC step, the FSM moves to DONE at the next edge. Latency is 1 + index of the highest set bit of b, with a minimum of 1 cycle in CALC.
  - b == 0 gives product 0 after 1 CALC cycle.
- Divide latency is unchanged.
- Undefined: fixed WIDTH-cycle latency for both operations.

Decomposition:
- Shared package seq_muldiv_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - OP_MUL = 1'b0 and OP_DIV = 1'b1 constants;
  - step-counter width function clog2(WIDTH).
- One natural sub-module: seq_muldiv_step, the combinational single-step datapath.
  - Inputs: op and current acc/mcand/mplier or rem/quo/divisor.
  - Outputs: next values of those registers.
  - The FSM/counter stays in the top level.

Test Plan:
- Multiply, WIDTH=4, op=0, a=15, b=15, start at edge T:
  - busy high for 4 cycles;
  - done in the cycle after edge T+4;
  - result = 8'd225, div_zero = 0.
- Divide, op=1, a=13, b=3: result = {4'd1, 4'd4}, i.e. remainder 1, quotient 4, with the same latency.
- Divide by zero, op=1, a=9, b=0: result = {4'd9, 4'hF}, div_zero = 1 at done.
- Ignored start and back-to-back:
  - start=1 with a=2, b=3 during CALC of 5×6 is ignored; result = 30.
  - Then start in the DONE cycle with 7÷2 gives a second done 5 cycles later with {1, 3}.
- Reset mid-operation:
  - rst pulsed in the 2nd CALC cycle of 9×9;
  - busy, done and result go to 0 immediately;
  - no done follows;
  - a new request 3×4 gives 12.
- Early termination (SEQ_MULDIV_EARLY_TERM_EN defined):
  - 7×1 gives done after 1 CALC cycle, result 7;
  - 7×8 gives done after 4 CALC cycles, result 56;
  - without the macro both take 4 cycles.
